// File: rtl/keypad_scan_pkg.sv
// Shared types for the keypad scanner: FSM state, key code layout,
// scan result bundle and column drive helper.
package keypad_scan_pkg;

  typedef enum logic {
    RELEASED = 1'b0,
    PRESSED  = 1'b1
  } state_e;

  typedef struct packed {
    logic [1:0] cidx;
    logic [1:0] ridx;
  } key_code_t;

  typedef struct packed {
    logic      hit;
    key_code_t code;
  } scan_res_t;

  localparam logic [3:0] COL_IDLE = 4'b1111;
  localparam scan_res_t  RES_NONE = '0;

  function automatic logic [3:0] col_drive(
    input logic [1:0] sel
  );
    return COL_IDLE & ~(4'b0001 << sel);
  endfunction

endpackage

// File: rtl/keypad_scan_sync_2ff.sv
// Two-flop synchronizer for asynchronous inputs.
// Resets to all-ones so idle pulled-up lines read as released.
module sync_2ff #(
  parameter int WIDTH = 4
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);

  logic [WIDTH-1:0] meta_q;
  logic [WIDTH-1:0] sync_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      meta_q <= '1;
      sync_q <= '1;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/keypad_scan.sv
// 4x4 keypad column scanner with scan-level debounce,
// single-key classification and a one-deep key handoff.
module keypad_scan
  import keypad_scan_pkg::*;
#(
  parameter int SCAN_COUNT     = 100000,
  parameter int DEBOUNCE_SCANS = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] row,
  output logic [3:0] col,
  output logic [3:0] key_code,
  output logic       key_valid,
  input  logic       key_ack,
  output logic       key_held,
  output logic       overrun
);

  localparam int CW =
    (SCAN_COUNT > 1) ? $clog2(SCAN_COUNT) : 1;
  localparam logic [CW-1:0] LAST = CW'(SCAN_COUNT - 1);
  localparam int SW = $clog2(DEBOUNCE_SCANS + 1);
  localparam logic [SW-1:0] DEB = SW'(DEBOUNCE_SCANS);

  logic [3:0]    row_s;
  logic [CW-1:0] cnt_q;
  logic [1:0]    sel_q;
  logic [1:0]    acc_q;
  key_code_t     acc_code_q;
  scan_res_t     prev_q;
  logic [SW-1:0] stable_q;
  state_e        state_q;
  key_code_t     code_q;
  logic          valid_q;
  logic          ovr_q;

  logic          sample;
  logic          scan_end;
  logic [2:0]    col_cnt;
  logic [2:0]    tot;
  logic [1:0]    acc_d;
  key_code_t     code_d;
  scan_res_t     res_d;
  logic [SW-1:0] stable_d;
  logic          settled;
  logic          press;
  logic          release_ev;
  logic          ack_ok;

  sync_2ff #(
    .WIDTH (4)
  ) u_sync (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .d_i    (row),
    .q_o    (row_s)
  );

  always_comb begin
    sample   = (cnt_q == LAST);
    scan_end = sample && (sel_q == 2'd3);
    col_cnt  = '0;
    code_d   = acc_code_q;
    for (int r = 0; r < 4; r++) begin
      if (!row_s[r]) begin
        col_cnt = col_cnt + 3'd1;
        code_d  = {sel_q, 2'(r)};
      end
    end
    tot   = {1'b0, acc_q} + col_cnt;
    // Saturate at two: only "none / one / many" matters.
    acc_d = (tot >= 3'd2) ? 2'd2 : tot[1:0];
    res_d = RES_NONE;
    if (tot == 3'd1) begin
      res_d.hit  = 1'b1;
      res_d.code = code_d;
    end
    if (res_d == prev_q) begin
      stable_d = (stable_q == DEB) ? DEB
                                   : stable_q + 1'b1;
    end else begin
      stable_d = SW'(1);
    end
    settled    = (stable_d == DEB);
    press      = scan_end && (state_q == RELEASED)
                 && res_d.hit && settled;
    release_ev = scan_end && (state_q == PRESSED)
                 && !res_d.hit && settled;
    ack_ok     = key_ack && valid_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q      <= '0;
      sel_q      <= '0;
      acc_q      <= '0;
      acc_code_q <= '0;
      prev_q     <= RES_NONE;
      stable_q   <= '0;
      state_q    <= RELEASED;
      code_q     <= '0;
      valid_q    <= 1'b0;
      ovr_q      <= 1'b0;
    end else begin
      if (sample) begin
        cnt_q <= '0;
        sel_q <= sel_q + 2'd1;
        if (scan_end) begin
          acc_q      <= '0;
          acc_code_q <= '0;
          prev_q     <= res_d;
          stable_q   <= stable_d;
        end else begin
          acc_q      <= acc_d;
          acc_code_q <= code_d;
        end
      end else begin
        cnt_q <= cnt_q + 1'b1;
      end

      unique case (1'b1)
        press:      state_q <= PRESSED;
        release_ev: state_q <= RELEASED;
        default:    state_q <= state_q;
      endcase

      // Pending unacked key wins; the new press is dropped.
      if (press && valid_q && !key_ack) begin
        ovr_q <= 1'b1;
      end else if (press) begin
        code_q  <= res_d.code;
        valid_q <= 1'b1;
        if (ack_ok) ovr_q <= 1'b0;
      end else if (ack_ok) begin
        valid_q <= 1'b0;
        ovr_q   <= 1'b0;
      end
    end
  end

  assign col       = col_drive(sel_q);
  assign key_code  = code_q;
  assign key_valid = valid_q;
  assign key_held  = (state_q == PRESSED);
  assign overrun   = ovr_q;

endmodule

// File: tb/tb_keypad_scan.sv
// Scoreboarded bench for keypad_scan: keypad model, event
// queue with expected code and cycle, per-scenario tasks.
module tb_keypad_scan;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [3:0]  row;
  logic [3:0]  col;
  logic [3:0]  key_code;
  logic        key_valid;
  logic        key_ack = 1'b0;
  logic        key_held;
  logic        overrun;
  logic [15:0] keys = '0;

  int total = 0;
  int bad = 0;
  int cyc = 0;

  typedef struct {
    logic [3:0] code;
    int         at;
  } exp_t;

  exp_t q[$];
  exp_t mon_e;
  logic pv = 1'b0;
  logic [3:0] pc = '0;

  always #5 clk = ~clk;

  keypad_scan #(
    .SCAN_COUNT     (4),
    .DEBOUNCE_SCANS (3)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .row       (row),
    .col       (col),
    .key_code  (key_code),
    .key_valid (key_valid),
    .key_ack   (key_ack),
    .key_held  (key_held),
    .overrun   (overrun)
  );

  // Key {c,r} pulls row r low while column c is driven low.
  always_comb begin
    row = 4'hF;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        if (!col[c] && keys[c*4+r]) row[r] = 1'b0;
  end

  always @(posedge clk or negedge rst_n)
    if (!rst_n) cyc <= 0;
    else cyc <= cyc + 1;

  // A load is valid rising or the code changing while valid.
  always @(negedge clk) begin
    if (!rst_n) begin
      pv = 1'b0;
      pc = '0;
    end else begin
      if (key_valid && (!pv || key_code != pc)) begin
        total++;
        if (q.size() == 0) begin
          bad++;
          $display("FAIL unexpected_event code=%h cyc=%0d",
                   key_code, cyc);
        end else begin
          mon_e = q.pop_front();
          if (key_code !== mon_e.code || cyc != mon_e.at) begin
            bad++;
            $display("FAIL event got=%h@%0d want=%h@%0d",
                     key_code, cyc, mon_e.code, mon_e.at);
          end
        end
      end
      pv = key_valid;
      pc = key_code;
    end
  end

  initial begin
    #200000;
    $display("FAIL timeout total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

  task automatic scans(input int n);
    repeat (16 * n) @(negedge clk);
  endtask

  task automatic align();
    for (int i = 0; i < 16 && (cyc % 16) != 0; i++)
      @(negedge clk);
  endtask

  task automatic ack_pulse();
    key_ack = 1'b1;
    @(negedge clk);
    key_ack = 1'b0;
  endtask

  task automatic test_reset();
    #12;
    total++;
    if ({col, key_code, key_valid, key_held, overrun}
        !== {4'b1110, 4'h0, 3'b000}) begin
      bad++;
      $display("FAIL reset got=%b want=%b",
               {col, key_code, key_valid, key_held, overrun},
               {4'b1110, 4'h0, 3'b000});
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_cols();
    logic [3:0] want;
    logic [3:0] one;
    one = 4'b0001;
    total++;
    if (col !== 4'b1110) begin
      bad++;
      $display("FAIL col0 got=%b want=1110", col);
    end
    for (int i = 1; i <= 4; i++) begin
      repeat (4) @(negedge clk);
      want = ~(one << (i % 4));
      total++;
      if (col !== want) begin
        bad++;
        $display("FAIL col_step%0d got=%b want=%b",
                 i, col, want);
      end
    end
  endtask

  task automatic test_single();
    int st;
    st = cyc;
    keys = 16'h0200;
    q.push_back('{4'h9, st + 48});
    scans(2);
    total++;
    if ({key_valid, key_held} !== 2'b00) begin
      bad++;
      $display("FAIL single_early got=%b want=00",
               {key_valid, key_held});
    end
    scans(1);
    total++;
    if ({key_valid, key_held, key_code} !== 6'b11_1001) begin
      bad++;
      $display("FAIL single_press got=%b want=111001",
               {key_valid, key_held, key_code});
    end
    scans(2);
    ack_pulse();
    total++;
    if (key_valid !== 1'b0) begin
      bad++;
      $display("FAIL single_ack got=%b want=0", key_valid);
    end
    align();
    keys = '0;
    scans(3);
    total++;
    if (key_held !== 1'b0) begin
      bad++;
      $display("FAIL single_release got=%b want=0", key_held);
    end
  endtask

  task automatic test_bounce();
    for (int s = 0; s < 10; s++) begin
      keys = (s % 2 == 0) ? 16'h0008 : 16'h0000;
      scans(1);
      total++;
      if ({key_valid, key_held} !== 2'b00) begin
        bad++;
        $display("FAIL bounce scan%0d got=%b want=00",
                 s, {key_valid, key_held});
      end
    end
    keys = '0;
  endtask

  task automatic test_ghost();
    keys = 16'h0042;
    for (int s = 0; s < 6; s++) begin
      scans(1);
      total++;
      if ({key_valid, key_held} !== 2'b00) begin
        bad++;
        $display("FAIL ghost scan%0d got=%b want=00",
                 s, {key_valid, key_held});
      end
    end
    keys = '0;
    scans(1);
  endtask

  task automatic test_overrun();
    int st;
    st = cyc;
    keys = 16'h0004;
    q.push_back('{4'h2, st + 48});
    scans(3);
    keys = '0;
    scans(3);
    total++;
    if (key_held !== 1'b0) begin
      bad++;
      $display("FAIL ovr_release got=%b want=0", key_held);
    end
    keys = 16'h8000;
    scans(3);
    total++;
    if ({key_code, key_valid, overrun, key_held}
        !== 7'b0010_111) begin
      bad++;
      $display("FAIL ovr_drop got=%b want=0010111",
               {key_code, key_valid, overrun, key_held});
    end
    ack_pulse();
    total++;
    if ({key_valid, overrun} !== 2'b00) begin
      bad++;
      $display("FAIL ovr_ack got=%b want=00",
               {key_valid, overrun});
    end
    align();
    keys = '0;
    scans(3);
  endtask

  task automatic test_ack_coincide();
    int st;
    st = cyc;
    keys = 16'h0400;
    q.push_back('{4'hA, st + 48});
    scans(3);
    keys = '0;
    scans(3);
    keys = 16'h0800;
    st = cyc;
    q.push_back('{4'hB, st + 48});
    scans(2);
    repeat (15) @(negedge clk);
    ack_pulse();
    total++;
    if ({key_valid, key_code, overrun} !== 6'b1_1011_0) begin
      bad++;
      $display("FAIL coincide got=%b want=110110",
               {key_valid, key_code, overrun});
    end
    ack_pulse();
    total++;
    if (key_valid !== 1'b0) begin
      bad++;
      $display("FAIL coincide_ack got=%b want=0", key_valid);
    end
    align();
    keys = '0;
    scans(3);
  endtask

  task automatic test_reset_held();
    int st;
    st = cyc;
    keys = 16'h0020;
    q.push_back('{4'h5, st + 48});
    scans(3);
    repeat (6) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    total++;
    if ({col, key_code, key_valid, key_held, overrun}
        !== {4'b1110, 4'h0, 3'b000}) begin
      bad++;
      $display("FAIL async_reset got=%b want=%b",
               {col, key_code, key_valid, key_held, overrun},
               {4'b1110, 4'h0, 3'b000});
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    q.push_back('{4'h5, 48});
    scans(2);
    total++;
    if ({key_valid, key_held} !== 2'b00) begin
      bad++;
      $display("FAIL rst_early got=%b want=00",
               {key_valid, key_held});
    end
    scans(1);
    total++;
    if ({key_valid, key_held, key_code} !== 6'b11_0101) begin
      bad++;
      $display("FAIL rst_press got=%b want=110101",
               {key_valid, key_held, key_code});
    end
    ack_pulse();
    align();
    keys = '0;
    scans(3);
    total++;
    if (key_held !== 1'b0) begin
      bad++;
      $display("FAIL rst_release got=%b want=0", key_held);
    end
  endtask

  initial begin
    test_reset();
    test_cols();
    test_single();
    test_bounce();
    test_ghost();
    test_overrun();
    test_ack_coincide();
    test_reset_held();
    @(negedge clk);
    total++;
    if (q.size() != 0) begin
      bad++;
      $display("FAIL missing_events got=%0d want=0", q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
